ex_mem_skid: RTL and testbench

- Parametrised EX→MEM pipeline stage. Carries the register-file write (enable, address, data) and the HI/LO write (enable, hi, lo) from execute to memory.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so MEM back-pressure does not form a combinational path into EX.
- Provides a synchronous flush for branch/exception squash.
- Exposes a forwarding tap of the head entry for the EX bypass network.

---
 rtl/ex_mem_skid_pkg.sv | 43 ++++
 rtl/ex_mem_skid_pipe_payload_reg.sv | 25 ++
 rtl/ex_mem_skid.sv | 159 +++++++++++++++
 tb/tb_ex_mem_skid.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_pkg.sv
// Shared constants, state encoding and payload layout for the EX->MEM skid stage.
package ex_mem_skid_pkg;

  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam int unsigned NOPRegAddr   = 0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  // Packed payload, MSB first: {wReg, wHiLo, wAddr, wData, hiData, loData}
  function automatic int unsigned payload_w(int unsigned addr_w, int unsigned data_w);
    return 2 + addr_w + 3 * data_w;
  endfunction

  function automatic int unsigned lo_lsb(int unsigned data_w);
    return 0 * data_w;
  endfunction

  function automatic int unsigned hi_lsb(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned wdata_lsb(int unsigned data_w);
    return 2 * data_w;
  endfunction

  function automatic int unsigned waddr_lsb(int unsigned data_w);
    return 3 * data_w;
  endfunction

  function automatic int unsigned whilo_bit(int unsigned addr_w, int unsigned data_w);
    return 3 * data_w + addr_w;
  endfunction

  function automatic int unsigned wreg_bit(int unsigned addr_w, int unsigned data_w);
    return 3 * data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/ex_mem_skid_pipe_payload_reg.sv
// Width-generic load-enabled register with synchronous active-low clear.
module pipe_payload_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Clear on reset, otherwise capture when loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline stage with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a forwarding tap of the head entry.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wReg,
  input  logic [ADDR_W-1:0] ex_wAddr,
  input  logic [DATA_W-1:0] ex_wData,
  input  logic              ex_wHiLo,
  input  logic [DATA_W-1:0] ex_hiData,
  input  logic [DATA_W-1:0] ex_loData,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wReg,
  output logic [ADDR_W-1:0] mem_wAddr,
  output logic [DATA_W-1:0] mem_wData,
  output logic              mem_wHiLo,
  output logic [DATA_W-1:0] mem_hiData,
  output logic [DATA_W-1:0] mem_loData,
  output logic              fwd_hit_en,
  output logic [1:0]        occ
);

  localparam int unsigned PW = payload_w(ADDR_W, DATA_W);

  state_e          r_state;
  state_e          w_state_next;
  logic            w_acc;
  logic            w_pop;
  logic            w_load_main;
  logic            w_load_skid;
  logic            w_main_from_skid;
  logic            w_wreg_in;
  logic [PW-1:0]   w_in_payload;
  logic [PW-1:0]   w_main_d;
  logic [PW-1:0]   w_main_q;
  logic [PW-1:0]   w_skid_q;

  assign w_acc = ex_valid & ex_ready;
  assign w_pop = mem_valid & mem_ready;

  // r0 is never a real write target, so drop its enable at capture time.
  assign w_wreg_in = (ex_wReg == WriteEnable && ex_wAddr != ADDR_W'(NOPRegAddr)) ?
                     WriteEnable : WriteDisable;
  assign w_in_payload = {w_wreg_in, ex_wHiLo, ex_wAddr, ex_wData, ex_hiData, ex_loData};
  assign w_main_d     = w_main_from_skid ? w_skid_q : w_in_payload;

  // Ready: registered-only with skid; combinational pass-through without.
  always_comb begin
    if (SKID != 0) begin
      ex_ready = rst_n & (r_state != StFull);
    end else begin
      ex_ready = rst_n & ((r_state == StEmpty) | mem_ready);
    end
  end

  // Next state and register load selects; flush wins over any same-cycle accept.
  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_acc) begin
          w_state_next = StOne;
          w_load_main  = 1'b1;
        end
      end
      StOne: begin
        if (w_acc && w_pop) begin
          w_load_main = 1'b1;
        end else if (w_acc && SKID != 0) begin
          w_state_next = StFull;
          w_load_skid  = 1'b1;
        end else if (w_pop) begin
          w_state_next = StEmpty;
        end
      end
      StFull: begin
        if (w_pop) begin
          w_state_next     = StOne;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_next = StEmpty;
    endcase
    if (flush) begin
      w_state_next = StEmpty;
      w_load_main  = 1'b0;
      w_load_skid  = 1'b0;
    end
  end

  // State register; reset dominates flush and transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  pipe_payload_reg #(
    .DATA_W(PW)
  ) u_main_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_load_main),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  if (SKID != 0) begin : g_skid
    pipe_payload_reg #(
      .DATA_W(PW)
    ) u_skid_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_load(w_load_skid),
      .i_d   (w_in_payload),
      .o_q   (w_skid_q)
    );
  end else begin : g_no_skid
    logic w_unused_skid;
    assign w_unused_skid = w_load_skid;
    assign w_skid_q      = '0;
  end

  assign mem_valid  = (r_state != StEmpty);
  assign mem_wReg   = w_main_q[wreg_bit(ADDR_W, DATA_W)] & mem_valid;
  assign mem_wHiLo  = w_main_q[whilo_bit(ADDR_W, DATA_W)] & mem_valid;
  assign mem_wAddr  = w_main_q[waddr_lsb(DATA_W) +: ADDR_W];
  assign mem_wData  = w_main_q[wdata_lsb(DATA_W) +: DATA_W];
  assign mem_hiData = w_main_q[hi_lsb(DATA_W) +: DATA_W];
  assign mem_loData = w_main_q[lo_lsb(DATA_W) +: DATA_W];
  assign fwd_hit_en = mem_wReg;

  // Occupancy count from state.
  always_comb begin
    occ = 2'd0;
    case (r_state)
      StOne:   occ = 2'd1;
      StFull:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: drives a SKID=1 and a SKID=0 instance from shared inputs and
// compares both against queue models of the stage.
module tb_ex_mem_skid;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 2 + AW + 3 * DW;

  typedef logic [PW-1:0] pl_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, ex_valid, ex_wReg, ex_wHiLo, mem_ready;
  logic [AW-1:0] ex_wAddr;
  logic [DW-1:0] ex_wData, ex_hiData, ex_loData;

  logic          rdy1, mv1, mwr1, mhl1, fwd1;
  logic [AW-1:0] ma1;
  logic [DW-1:0] md1, mhi1, mlo1;
  logic [1:0]    occ1;
  logic          rdy0, mv0, mwr0, mhl0, fwd0;
  logic [AW-1:0] ma0;
  logic [DW-1:0] md0, mhi0, mlo0;
  logic [1:0]    occ0;

  pl_t q1[$];
  pl_t q0[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  always #5 clk = ~clk;

  ex_mem_skid #(.DATA_W(DW), .ADDR_W(AW), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(rdy1),
    .ex_wReg(ex_wReg), .ex_wAddr(ex_wAddr), .ex_wData(ex_wData), .ex_wHiLo(ex_wHiLo),
    .ex_hiData(ex_hiData), .ex_loData(ex_loData), .mem_valid(mv1), .mem_ready(mem_ready),
    .mem_wReg(mwr1), .mem_wAddr(ma1), .mem_wData(md1), .mem_wHiLo(mhl1),
    .mem_hiData(mhi1), .mem_loData(mlo1), .fwd_hit_en(fwd1), .occ(occ1)
  );

  ex_mem_skid #(.DATA_W(DW), .ADDR_W(AW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(rdy0),
    .ex_wReg(ex_wReg), .ex_wAddr(ex_wAddr), .ex_wData(ex_wData), .ex_wHiLo(ex_wHiLo),
    .ex_hiData(ex_hiData), .ex_loData(ex_loData), .mem_valid(mv0), .mem_ready(mem_ready),
    .mem_wReg(mwr0), .mem_wAddr(ma0), .mem_wData(md0), .mem_wHiLo(mhl0),
    .mem_hiData(mhi0), .mem_loData(mlo0), .fwd_hit_en(fwd0), .occ(occ0)
  );

  function automatic pl_t in_pl();
    return {ex_wReg && (ex_wAddr != '0), ex_wHiLo, ex_wAddr, ex_wData, ex_hiData, ex_loData};
  endfunction

  task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic hl, input logic [DW-1:0] hi,
                       input logic [DW-1:0] lo);
    ex_valid = v; ex_wReg = wr; ex_wAddr = a; ex_wData = d;
    ex_wHiLo = hl; ex_hiData = hi; ex_loData = lo;
  endtask

  // Advance the FIFO models by one clock using the current inputs, then the DUT clock.
  task automatic tick();
    bit r1, r0, p1, p0;
    r1 = rst_n && (q1.size() < 2);
    r0 = rst_n && (q0.size() == 0 || mem_ready);
    p1 = (q1.size() > 0) && mem_ready;
    p0 = (q0.size() > 0) && mem_ready;
    if (!rst_n) begin
      q1.delete(); q0.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (p0) void'(q0.pop_front());
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (ex_valid && r1) q1.push_back(in_pl());
        if (ex_valid && r0) q0.push_back(in_pl());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd7, 32'h55, 1'b1, 32'h66, 32'h77);
    tick(); tick();
    n_chk++; if (rdy1 !== 1'b0) $display("FAIL reset_ready1 got %b want 0", rdy1); else n_pass++;
    n_chk++; if (rdy0 !== 1'b0) $display("FAIL reset_ready0 got %b want 0", rdy0); else n_pass++;
    n_chk++; if (mv1 !== 1'b0) $display("FAIL reset_valid1 got %b want 0", mv1); else n_pass++;
    n_chk++; if (occ1 !== 2'd0) $display("FAIL reset_occ1 got %0d want 0", occ1); else n_pass++;
    n_chk++; if (ma1 !== 5'd0) $display("FAIL reset_addr1 got %0d want 0", ma1); else n_pass++;
    n_chk++; if ({md1, mhi1, mlo1} !== '0)
      $display("FAIL reset_data1 got %h %h %h want 0", md1, mhi1, mlo1); else n_pass++;
    n_chk++; if ({mwr1, mhl1} !== 2'b00) $display("FAIL reset_en1 got %b%b want 00", mwr1, mhl1);
    else n_pass++;
    n_chk++; if ({mv0, occ0} !== 3'd0) $display("FAIL reset_state0 got %b/%0d want 0/0", mv0, occ0);
    else n_pass++;
    rst_n = 1'b1; ex_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    mem_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    tick();
    ex_valid = 1'b0;
    n_chk++; if (mv1 !== 1'b1) $display("FAIL single_valid got %b want 1", mv1); else n_pass++;
    n_chk++; if (mwr1 !== 1'b1) $display("FAIL single_wreg got %b want 1", mwr1); else n_pass++;
    n_chk++; if (ma1 !== 5'd5) $display("FAIL single_addr got %0d want 5", ma1); else n_pass++;
    n_chk++; if (md1 !== 32'hDEADBEEF) $display("FAIL single_data got %h want deadbeef", md1);
    else n_pass++;
    n_chk++; if (fwd1 !== 1'b1) $display("FAIL single_fwd got %b want 1", fwd1); else n_pass++;
    tick();
    n_chk++; if (occ1 !== 2'd0) $display("FAIL single_drain got %0d want 0", occ1); else n_pass++;
  endtask

  task automatic test_back_pressure();
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 1'b1, 5'd2, 32'h2, 1'b0, 32'h0, 32'h0); tick();
    drive(1'b1, 1'b1, 5'd3, 32'h3, 1'b0, 32'h0, 32'h0); #1;
    n_chk++; if (occ1 !== 2'd2) $display("FAIL bp_occ got %0d want 2", occ1); else n_pass++;
    n_chk++; if (rdy1 !== 1'b0) $display("FAIL bp_ready got %b want 0", rdy1); else n_pass++;
    tick(); tick();
    n_chk++; if (md1 !== 32'h1) $display("FAIL bp_hold got %h want 1", md1); else n_pass++;
    n_chk++; if (occ1 !== 2'd2) $display("FAIL bp_hold_occ got %0d want 2", occ1); else n_pass++;
    mem_ready = 1'b1; #1;
    n_chk++; if (rdy1 !== 1'b0) $display("FAIL bp_ready_nocomb got %b want 0", rdy1); else n_pass++;
    n_chk++; if (md1 !== 32'h1) $display("FAIL bp_order_a got %h want 1", md1); else n_pass++;
    tick();
    n_chk++; if (md1 !== 32'h2) $display("FAIL bp_order_b got %h want 2", md1); else n_pass++;
    tick();
    n_chk++; if (md1 !== 32'h3) $display("FAIL bp_order_c got %h want 3", md1); else n_pass++;
    ex_valid = 1'b0;
    tick();
    n_chk++; if (mv1 !== 1'b0) $display("FAIL bp_empty got %b want 0", mv1); else n_pass++;
  endtask

  task automatic test_r0();
    mem_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b0, 32'h0, 32'h0);
    tick();
    ex_valid = 1'b0;
    n_chk++; if (mv1 !== 1'b1) $display("FAIL r0_valid got %b want 1", mv1); else n_pass++;
    n_chk++; if (mwr1 !== 1'b0) $display("FAIL r0_wreg got %b want 0", mwr1); else n_pass++;
    n_chk++; if (fwd1 !== 1'b0) $display("FAIL r0_fwd got %b want 0", fwd1); else n_pass++;
    n_chk++; if (md1 !== 32'hFFFF) $display("FAIL r0_data got %h want ffff", md1); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 32'h11, 1'b1, 32'h1, 32'h2); tick();
    drive(1'b1, 1'b1, 5'd6, 32'h22, 1'b1, 32'h3, 32'h4); tick();
    drive(1'b1, 1'b1, 5'd7, 32'h33, 1'b1, 32'h5, 32'h6);
    flush = 1'b1; #1;
    n_chk++; if (occ1 !== 2'd2) $display("FAIL flush_pre_occ got %0d want 2", occ1); else n_pass++;
    tick();
    flush = 1'b0; ex_valid = 1'b0;
    n_chk++; if (occ1 !== 2'd0) $display("FAIL flush_occ got %0d want 0", occ1); else n_pass++;
    n_chk++; if ({mv1, mwr1, mhl1, fwd1} !== 4'b0)
      $display("FAIL flush_gate got %b%b%b%b want 0000", mv1, mwr1, mhl1, fwd1); else n_pass++;
    n_chk++; if ({mv0, mwr0, mhl0} !== 3'b0)
      $display("FAIL flush_gate0 got %b%b%b want 000", mv0, mwr0, mhl0); else n_pass++;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (mv1 !== 1'b0) $display("FAIL flush_leak got %b want 0 (cycle %0d)", mv1, i);
      else n_pass++;
    end
  endtask

  task automatic test_skid0_throughput();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b1, 32'hA + 32'(i), 32'hB + 32'(i));
      #1;
      n_chk++; if (rdy0 !== 1'b1) $display("FAIL s0_ready got %b want 1 (i=%0d)", rdy0, i);
      else n_pass++;
      tick();
      n_chk++; if ({mv0, mhl0, occ0} !== 4'b1101)
        $display("FAIL s0_state got v%b hl%b occ%0d want 1/1/1 (i=%0d)", mv0, mhl0, occ0, i);
      else n_pass++;
      n_chk++; if ({md0, mhi0, mlo0} !== {32'h100 + 32'(i), 32'hA + 32'(i), 32'hB + 32'(i)})
        $display("FAIL s0_payload got %h %h %h (i=%0d)", md0, mhi0, mlo0, i); else n_pass++;
    end
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd20, 32'h999, 1'b0, 32'h0, 32'h0);
    #1;
    n_chk++; if (rdy0 !== 1'b0) $display("FAIL s0_stall_ready got %b want 0", rdy0); else n_pass++;
    tick();
    n_chk++; if (md0 !== 32'h103) $display("FAIL s0_stall_hold got %h want 103", md0); else n_pass++;
    mem_ready = 1'b1; ex_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    pl_t h;
    int  sz;
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(63, 0) != 0);
      flush     = ($urandom_range(15, 0) == 0);
      mem_ready = ($urandom_range(2, 0) != 0);
      drive(1'($urandom_range(3, 0) != 0), 1'($urandom), AW'($urandom), $urandom,
            1'($urandom), $urandom, $urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic          a_rdy, a_mv, a_mwr, a_mhl, a_fwd, e_rdy;
        logic [1:0]    a_occ;
        logic [AW-1:0] a_ma;
        logic [DW-1:0] a_md, a_hi, a_lo;
        sz = (d == 1) ? q1.size() : q0.size();
        h  = '0;
        if (sz > 0) h = (d == 1) ? q1[0] : q0[0];
        e_rdy = (d == 1) ? (rst_n && sz < 2) : (rst_n && (sz == 0 || mem_ready));
        a_rdy = d == 1 ? rdy1 : rdy0; a_mv  = d == 1 ? mv1  : mv0;
        a_mwr = d == 1 ? mwr1 : mwr0; a_mhl = d == 1 ? mhl1 : mhl0;
        a_fwd = d == 1 ? fwd1 : fwd0; a_occ = d == 1 ? occ1 : occ0;
        a_ma  = d == 1 ? ma1  : ma0;  a_md  = d == 1 ? md1  : md0;
        a_hi  = d == 1 ? mhi1 : mhi0; a_lo  = d == 1 ? mlo1 : mlo0;
        n_chk++;
        if ({a_rdy, a_mv, a_occ} !== {e_rdy, sz > 0, 2'(sz)})
          $display("FAIL rnd_ctl skid%0d cyc%0d got r%b v%b o%0d want r%b v%b o%0d", d, c,
                   a_rdy, a_mv, a_occ, e_rdy, sz > 0, sz);
        else n_pass++;
        n_chk++;
        if ({a_mwr, a_mhl, a_fwd} !== {h[PW-1], h[PW-2], h[PW-1]})
          $display("FAIL rnd_en skid%0d cyc%0d got %b%b%b want %b%b%b", d, c, a_mwr, a_mhl,
                   a_fwd, h[PW-1], h[PW-2], h[PW-1]);
        else n_pass++;
        if (sz > 0) begin
          n_chk++;
          if ({a_ma, a_md, a_hi, a_lo} !== h[PW-3:0])
            $display("FAIL rnd_payload skid%0d cyc%0d got %h want %h", d, c,
                     {a_ma, a_md, a_hi, a_lo}, h[PW-3:0]);
          else n_pass++;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_r0();
    test_flush();
    test_skid0_throughput();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
